// File: rtl/api_rx_arb.sv
// rtl/api_rx_arb.sv - packet-level round-robin arbiter feeding the shared rx FIFO
// Optional first-word channel tagging is enabled by defining API_RX_TAG_EN.
module api_rx_arb #(
    parameter int CH_NUM     = 2,
    parameter int PKT_LEN    = 2,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_NUM-1:0]   ch_en,
    input  logic [CH_NUM-1:0]   req,
    input  logic [32*CH_NUM-1:0] din,
    output logic [CH_NUM-1:0]   ack,
    output logic                rx_fifo_wr_en,
    output logic [31:0]         rx_fifo_din,
    input  logic [9:0]          rx_fifo_data_count,
    output logic                busy,
    output logic [5:0]          grant_ch,
    output logic [15:0]         pkt_cnt
);

    typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} state_t;

    state_t             state;
    logic [5:0]         ptr;
    logic [3:0]         word_cnt;
    logic [CH_NUM-1:0]  pend;
    logic [10:0]        free;
    logic               pick_valid;
    logic [5:0]         pick;
    logic               cur_req;
    logic [31:0]        cur_word;
    logic [31:0]        out_word;
    logic [5:0]         next_ptr;

    assign pend     = req & ch_en;
    assign busy     = (state != IDLE);
    assign next_ptr = (grant_ch == 6'(CH_NUM - 1)) ? 6'd0 : grant_ch + 6'd1;

    // An over-reported occupancy means no room at all rather than a wrapped free count.
    always_comb begin
        if ({1'b0, rx_fifo_data_count} > 11'(FIFO_DEPTH))
            free = 11'd0;
        else
            free = 11'(FIFO_DEPTH) - {1'b0, rx_fifo_data_count};
    end

    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick       = 6'd0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CH_NUM)
                idx = idx - CH_NUM;
            if (!pick_valid && pend[idx]) begin
                pick_valid = 1'b1;
                pick       = 6'(idx);
            end
        end
    end

    always_comb begin
        cur_req  = 1'b0;
        cur_word = 32'd0;
        ack      = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (6'(k) == grant_ch) begin
                cur_req  = req[k];
                cur_word = din[32*k +: 32];
                ack[k]   = (state == XFER) && req[k];
            end
        end
    end

`ifdef API_RX_TAG_EN
    assign out_word = (word_cnt == 4'd0) ? {grant_ch, cur_word[25:0]} : cur_word;
`else
    assign out_word = cur_word;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 6'd0;
            grant_ch      <= 6'd0;
            word_cnt      <= 4'd0;
            pkt_cnt       <= 16'd0;
            rx_fifo_wr_en <= 1'b0;
            rx_fifo_din   <= 32'd0;
        end else begin
            rx_fifo_wr_en <= |ack;
            if (|ack)
                rx_fifo_din <= out_word;
            case (state)
                IDLE: begin
                    if (|pend)
                        state <= ARB;
                end
                ARB: begin
                    if (!pick_valid) begin
                        state <= IDLE;
                    end else if (free >= 11'(PKT_LEN)) begin
                        grant_ch <= pick;
                        word_cnt <= 4'd0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    // A dropped req just stalls the packet; it never times out.
                    if (cur_req) begin
                        word_cnt <= word_cnt + 4'd1;
                        if (word_cnt == 4'(PKT_LEN - 1))
                            state <= GAP;
                    end
                end
                GAP: begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                    ptr     <= next_ptr;
                    state   <= (|pend) ? ARB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_api_rx_arb.sv
// tb/tb_api_rx_arb.sv - directed self-checking bench for api_rx_arb (CH_NUM=2, PKT_LEN=2)
module tb_api_rx_arb;

`ifdef API_RX_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  ch_en;
    logic [1:0]  req;
    logic [63:0] din;
    logic [1:0]  ack;
    logic        rx_fifo_wr_en;
    logic [31:0] rx_fifo_din;
    logic [9:0]  rx_fifo_data_count;
    logic        busy;
    logic [5:0]  grant_ch;
    logic [15:0] pkt_cnt;

    int errors = 0;
    int checks = 0;

    api_rx_arb #(.CH_NUM(2), .PKT_LEN(2), .FIFO_DEPTH(512)) dut (
        .clk                (clk),
        .rst                (rst),
        .ch_en              (ch_en),
        .req                (req),
        .din                (din),
        .ack                (ack),
        .rx_fifo_wr_en      (rx_fifo_wr_en),
        .rx_fifo_din        (rx_fifo_din),
        .rx_fifo_data_count (rx_fifo_data_count),
        .busy               (busy),
        .grant_ch           (grant_ch),
        .pkt_cnt            (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] first_exp(input logic [5:0] ch, input logic [31:0] w);
        return TAG ? {ch, w[25:0]} : w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered during an ARB cycle whose next edge grants ch; returns just after the GAP edge.
    task automatic do_pkt(input int ch, input logic [31:0] w0, input logic [31:0] w1, input bit drop);
        logic [31:0] oh;
        oh = 32'(1) << ch;
        din[32*ch +: 32] = w0;
        @(negedge clk);
        check("arb_ack", 32'(ack), 32'd0);
        check("arb_busy", 32'(busy), 32'd1);
        cyc();
        @(negedge clk);
        check("w0_ack", 32'(ack), oh);
        cyc();
        din[32*ch +: 32] = w1;
        @(negedge clk);
        check("w1_ack", 32'(ack), oh);
        check("push0_en", 32'(rx_fifo_wr_en), 32'd1);
        check("push0_data", rx_fifo_din, first_exp(6'(ch), w0));
        cyc();
        if (drop)
            req = 2'b00;
        @(negedge clk);
        check("gap_ack", 32'(ack), 32'd0);
        check("push1_en", 32'(rx_fifo_wr_en), 32'd1);
        check("push1_data", rx_fifo_din, w1);
        check("grant_ch", 32'(grant_ch), 32'(ch));
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        ch_en = 2'b00;
        req = 2'b00;
        din = 64'd0;
        rx_fifo_data_count = 10'd0;
        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_wr_en", 32'(rx_fifo_wr_en), 32'd0);
        check("rst_din", rx_fifo_din, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_ch), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single source
        ch_en = 2'b11;
        req = 2'b01;
        cyc();
        do_pkt(0, 32'hA000_0001, 32'hA000_0002, 1'b1);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("t1_wr_en", 32'(rx_fifo_wr_en), 32'd0);

        // full FIFO holds the grant, then exactly one packet of room releases it
        rx_fifo_data_count = 10'd511;
        req = 2'b10;
        cyc();
        repeat (3) begin
            @(negedge clk);
            check("full_ack", 32'(ack), 32'd0);
            check("full_busy", 32'(busy), 32'd1);
            cyc();
        end
        rx_fifo_data_count = 10'd510;
        do_pkt(1, 32'hB000_0001, 32'hB000_0002, 1'b1);
        @(negedge clk);
        check("t3_wr_en", 32'(rx_fifo_wr_en), 32'd0);
        check("t3_pkt_cnt", 32'(pkt_cnt), 32'd2);
        rx_fifo_data_count = 10'd0;

        // round robin, back-to-back packets
        req = 2'b11;
        cyc();
        do_pkt(0, 32'hC000_0001, 32'hC000_0002, 1'b0);
        do_pkt(1, 32'hFFFF_FFFF, 32'hD000_0002, 1'b0);
        do_pkt(0, 32'hC000_0003, 32'hC000_0004, 1'b0);
        do_pkt(1, 32'hD000_0003, 32'hD000_0004, 1'b1);
        @(negedge clk);
        check("t2_pkt_cnt", 32'(pkt_cnt), 32'd6);
        check("t2_busy", 32'(busy), 32'd0);

        // stall mid-packet
        req = 2'b01;
        din[31:0] = 32'hE000_0001;
        cyc();
        cyc();
        @(negedge clk);
        check("st_w0_ack", 32'(ack), 32'd1);
        cyc();
        req = 2'b00;
        din[31:0] = 32'hE000_0002;
        @(negedge clk);
        check("st_drop_ack", 32'(ack), 32'd0);
        check("st_push0_en", 32'(rx_fifo_wr_en), 32'd1);
        check("st_push0_data", rx_fifo_din, first_exp(6'd0, 32'hE000_0001));
        repeat (2) begin
            cyc();
            @(negedge clk);
            check("st_hold_ack", 32'(ack), 32'd0);
            check("st_hold_wr_en", 32'(rx_fifo_wr_en), 32'd0);
            check("st_hold_busy", 32'(busy), 32'd1);
        end
        cyc();
        req = 2'b01;
        @(negedge clk);
        check("st_w1_ack", 32'(ack), 32'd1);
        check("st_w1_wr_en", 32'(rx_fifo_wr_en), 32'd0);
        cyc();
        req = 2'b11;
        ch_en = 2'b01;
        @(negedge clk);
        check("st_push1_en", 32'(rx_fifo_wr_en), 32'd1);
        check("st_push1_data", rx_fifo_din, 32'hE000_0002);
        cyc();
        // pointer now favours ch1, but ch1 is masked
        do_pkt(0, 32'hF000_0001, 32'hF000_0002, 1'b1);
        req = 2'b10;
        repeat (2) begin
            cyc();
            @(negedge clk);
            check("mask_ack", 32'(ack), 32'd0);
            check("mask_busy", 32'(busy), 32'd0);
        end
        check("t4_pkt_cnt", 32'(pkt_cnt), 32'd8);

        // asynchronous reset in the middle of a ch1 packet
        ch_en = 2'b11;
        din[63:32] = 32'h1234_5678;
        cyc();
        cyc();
        @(negedge clk);
        check("rs_w0_ack", 32'(ack), 32'd2);
        cyc();
        @(negedge clk);
        check("rs_push0_en", 32'(rx_fifo_wr_en), 32'd1);
        check("rs_push0_data", rx_fifo_din, first_exp(6'd1, 32'h1234_5678));
        #2;
        rst = 1'b1;
        #1;
        check("rs_ack", 32'(ack), 32'd0);
        check("rs_wr_en", 32'(rx_fifo_wr_en), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_pkt_cnt", 32'(pkt_cnt), 32'd0);
        req = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        do_pkt(0, 32'h5500_0001, 32'h5500_0002, 1'b1);
        @(negedge clk);
        check("t5_pkt_cnt", 32'(pkt_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
